// File: rtl/conf_regs_pkg.sv
// Shared definitions for the e-GPU configuration register target: register map,
// bit positions and the response-buffer entry. PERF_CYC exists only with CONF_REGS_PERF_CNT_EN.
package conf_regs_pkg;

    localparam logic [4:0] CONF_CTRL_OFF   = 5'h00;
    localparam logic [4:0] CONF_START_OFF  = 5'h04;
    localparam logic [4:0] CONF_STATUS_OFF = 5'h08;
    localparam logic [4:0] CONF_KPC_OFF    = 5'h0C;
    localparam logic [4:0] CONF_ARGS_OFF   = 5'h10;
    localparam logic [4:0] CONF_NUMG_OFF   = 5'h14;
    localparam logic [4:0] CONF_PERF_OFF   = 5'h18;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned START_GO_BIT    = 0;
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    localparam logic [31:0] CONF_DEAD_VALUE = 32'hBADC_0FFE;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_entry_t;

    function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/conf_rsp_fifo.sv
// In-order response buffer for the configuration target; DEPTH entries of rsp_entry_t.
module conf_rsp_fifo
    import conf_regs_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  rsp_entry_t    din_i,
    input  logic          pop_i,
    output rsp_entry_t    dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST_IDX = PW'(DEPTH - 1);

    rsp_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/conf_regs_obi_target.sv
// OBI responder for the e-GPU configuration registers: decode, byte-enabled writes,
// buffered responses, kernel launch/busy/done. Define CONF_REGS_PERF_CNT_EN for PERF_CYC at 0x18.
module conf_regs_obi_target
    import conf_regs_pkg::*;
#(
    parameter int unsigned RSP_DEPTH  = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter logic [31:0] DEAD_VALUE = CONF_DEAD_VALUE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              start_o,
    output logic [31:0]       kernel_pc_o,
    output logic [31:0]       args_ptr_o,
    output logic [15:0]       num_groups_o,
    input  logic              gpu_done_i
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic        ctrl_en_q, ctrl_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        start_q;
    logic [31:0] kpc_q, kpc_d;
    logic [31:0] args_q, args_d;
    logic [15:0] numg_q, numg_d;
    logic [31:0] numg_merged;
`ifdef CONF_REGS_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
`endif

    logic             accept, wr_acc, launch;
    logic [4:0]       reg_off;
    logic [31:0]      rd_data;
    logic             rd_err;
    rsp_entry_t       rsp_in, rsp_head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             unused_ok;

    assign reg_off = {addr_i[4:2], 2'b00};
    assign gnt_o   = req_i & ~fifo_full & ~rst_i;
    assign accept  = req_i & gnt_o;
    assign wr_acc  = accept & we_i;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (reg_off)
            CONF_CTRL_OFF:   rd_data[CTRL_EN_BIT] = ctrl_en_q;
            CONF_START_OFF:  rd_data = '0;
            CONF_STATUS_OFF: begin
                rd_data[STATUS_BUSY_BIT] = busy_q;
                rd_data[STATUS_DONE_BIT] = done_q;
            end
            CONF_KPC_OFF:    rd_data = kpc_q;
            CONF_ARGS_OFF:   rd_data = args_q;
            CONF_NUMG_OFF:   rd_data = {16'h0000, numg_q};
`ifdef CONF_REGS_PERF_CNT_EN
            CONF_PERF_OFF:   rd_data = perf_q;
`endif
            default: begin
                rd_data = DEAD_VALUE;
                rd_err  = 1'b1;
            end
        endcase
    end

    assign rsp_in.rdata = we_i ? 32'h0 : rd_data;
    assign rsp_in.err   = rd_err;
    assign numg_merged  = apply_be({16'h0000, numg_q}, wdata_i, be_i);

    always_comb begin
        ctrl_en_d = ctrl_en_q;
        busy_d    = busy_q;
        done_d    = done_q;
        kpc_d     = kpc_q;
        args_d    = args_q;
        numg_d    = numg_q;
        launch    = 1'b0;
        if (wr_acc) begin
            case (reg_off)
                CONF_CTRL_OFF:   if (be_i[0]) ctrl_en_d = wdata_i[CTRL_EN_BIT];
                CONF_START_OFF:  launch = be_i[0] & wdata_i[START_GO_BIT] & ctrl_en_q & ~busy_q;
                CONF_STATUS_OFF: if (be_i[0] & wdata_i[STATUS_DONE_BIT]) done_d = 1'b0;
                CONF_KPC_OFF:    kpc_d  = apply_be(kpc_q, wdata_i, be_i);
                CONF_ARGS_OFF:   args_d = apply_be(args_q, wdata_i, be_i);
                CONF_NUMG_OFF:   numg_d = numg_merged[15:0];
                default: ;
            endcase
        end
        if (launch) begin
            busy_d = 1'b1;
            done_d = 1'b0;
        end
        // Completion is applied last so it wins over a same-cycle done clear.
        if (gpu_done_i & busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

`ifdef CONF_REGS_PERF_CNT_EN
    always_comb begin
        perf_d = perf_q;
        if (launch) begin
            perf_d = '0;
        end else if (busy_q) begin
            perf_d = perf_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            kpc_q     <= '0;
            args_q    <= '0;
            numg_q    <= '0;
`ifdef CONF_REGS_PERF_CNT_EN
            perf_q    <= '0;
`endif
        end else begin
            ctrl_en_q <= ctrl_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            start_q   <= launch;
            kpc_q     <= kpc_d;
            args_q    <= args_d;
            numg_q    <= numg_d;
`ifdef CONF_REGS_PERF_CNT_EN
            perf_q    <= perf_d;
`endif
        end
    end

    conf_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .din_i   (rsp_in),
        .pop_i   (rready_i & rvalid_o),
        .dout_o  (rsp_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rvalid_o     = ~fifo_empty & ~rst_i;
    assign rdata_o      = rvalid_o ? rsp_head.rdata : 32'h0;
    assign err_o        = rvalid_o & rsp_head.err;
    assign start_o      = start_q & ~rst_i;
    assign kernel_pc_o  = kpc_q;
    assign args_ptr_o   = args_q;
    assign num_groups_o = numg_q;

    // Address bits outside [4:2] are deliberately not decoded.
    assign unused_ok = ^{addr_i[ADDR_W-1:5], addr_i[1:0], fifo_count};

endmodule

// File: tb/tb_conf_regs_obi_target.sv
// Self-checking bench for conf_regs_obi_target: directed scenarios plus random traffic
// against a word-level register model with a response queue.
module tb_conf_regs_obi_target;

    localparam int RSP_DEPTH = 2;
    localparam logic [31:0] DEAD = 32'hBADC_0FFE;
`ifdef CONF_REGS_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, req_i = 1'b0, we_i = 1'b0, rready_i = 1'b0, gpu_done_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        gnt_o, rvalid_o, err_o, start_o;
    logic [31:0] rdata_o, kernel_pc_o, args_ptr_o;
    logic [15:0] num_groups_o;

    always #5 clk = ~clk;

    conf_regs_obi_target #(.RSP_DEPTH(RSP_DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o), .start_o(start_o),
        .kernel_pc_o(kernel_pc_o), .args_ptr_o(args_ptr_o), .num_groups_o(num_groups_o),
        .gpu_done_i(gpu_done_i)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [31:0] d; logic e; } rsp_t;
    rsp_t        exp_q[$];
    logic [31:0] m_reg [8];
    logic        m_busy, m_done;
    logic [31:0] m_perf;
    logic        exp_start, last_acc, last_err;
    logic [31:0] last_rdata;
    int          n_start, n_pop;

    function automatic logic [31:0] wmask(input logic [2:0] off);
        case (off)
            3'd0:    return 32'h0000_0001;
            3'd5:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic is_mapped(input logic [2:0] off);
        return (off != 3'd7) && (off != 3'd6 || PERF_EN);
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd1:    return 32'h0;
            3'd2:    return {30'd0, m_done, m_busy};
            3'd6:    return PERF_EN ? m_perf : DEAD;
            3'd7:    return DEAD;
            default: return m_reg[off];
        endcase
    endfunction

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_busy = 0; m_done = 0; m_perf = '0; exp_start = 0;
    endtask

    // One clock cycle: check DUT against the model, then advance model and DUT together.
    task automatic tick();
        logic        acc, launch, done_clr;
        logic [2:0]  off;
        logic [31:0] bm;
        rsp_t        r;
        #1;
        chk("start_o", 32'(start_o), 32'(exp_start));
        if (start_o) n_start++;
        chk("kernel_pc_o", kernel_pc_o, m_reg[3]);
        chk("args_ptr_o", args_ptr_o, m_reg[4]);
        chk("num_groups_o", {16'd0, num_groups_o}, m_reg[5]);
        chk("rvalid_o", 32'(rvalid_o), 32'(exp_q.size() != 0));
        if (req_i) chk("gnt_o", 32'(gnt_o), 32'(exp_q.size() < RSP_DEPTH));
        acc = req_i && (exp_q.size() < RSP_DEPTH);
        if (rvalid_o && rready_i && exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("rdata_o", rdata_o, r.d);
            chk("err_o", 32'(err_o), 32'(r.e));
            last_rdata = rdata_o;
            last_err   = err_o;
            n_pop++;
        end
        off = addr_i[4:2];
        launch = 0;
        done_clr = 0;
        if (acc) begin
            r.d = we_i ? 32'h0 : model_read(off);
            r.e = !is_mapped(off);
            exp_q.push_back(r);
            if (we_i) begin
                bm = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
                case (off)
                    3'd1: launch = be_i[0] && wdata_i[0] && m_reg[0][0] && !m_busy;
                    3'd2: done_clr = be_i[0] && wdata_i[1];
                    3'd0, 3'd3, 3'd4, 3'd5:
                        m_reg[off] = ((m_reg[off] & ~bm) | (wdata_i & bm)) & wmask(off);
                    default: ;
                endcase
            end
        end
        if (launch) m_perf = 0;
        else if (m_busy) m_perf = m_perf + 1;
        if (done_clr) m_done = 0;
        if (launch) begin m_busy = 1; m_done = 0; end
        if (gpu_done_i && m_busy) begin m_busy = 0; m_done = 1; end
        exp_start = launch;
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_i = 1;
        repeat (cycles) begin
            #1;
            chk("rst_gnt", 32'(gnt_o), 0);
            chk("rst_rvalid", 32'(rvalid_o), 0);
            chk("rst_start", 32'(start_o), 0);
            chk("rst_err", 32'(err_o), 0);
            @(posedge clk);
            @(negedge clk);
        end
        rst_i = 0;
        req_i = 0;
        model_clear();
    endtask

    task automatic put(input logic w, input logic [2:0] off, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] rnd;
        rnd = $urandom();
        req_i = 1; we_i = w; be_i = be; wdata_i = d;
        addr_i = {rnd[31:5], off, rnd[1:0]};
    endtask

    task automatic wait_acc();
        int n = 0;
        last_acc = 0;
        while (!last_acc && n < 40) begin tick(); n++; end
        if (!last_acc) chk("acc_timeout", 0, 1);
        req_i = 0;
    endtask

    task automatic xfer(input logic w, input logic [2:0] off, input logic [3:0] be, input logic [31:0] d);
        put(w, off, be, d);
        wait_acc();
    endtask

    task automatic drain();
        int n = 0;
        rready_i = 1;
        while (exp_q.size() != 0 && n < 40) begin tick(); n++; end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend;
        n_start = 0; n_pop = 0; last_rdata = '0; last_err = 0; last_acc = 0;
        model_clear();
        @(negedge clk);
        req_i = 1;
        do_reset(3);
        idle(1);
        chk("reset_kpc", kernel_pc_o, 0);
        chk("reset_numg", {16'd0, num_groups_o}, 0);

        // write/read KERNEL_PC
        rready_i = 1;
        xfer(1, 3'd3, 4'hF, 32'h0000_1000);
        xfer(0, 3'd3, 4'hF, 32'h0);
        drain();
        chk("kpc_readback", last_rdata, 32'h0000_1000);
        chk("kpc_err", 32'(last_err), 0);

        // partial byte-enable write
        xfer(1, 3'd4, 4'hF, 32'h1111_2222);
        xfer(1, 3'd4, 4'b0011, 32'hAAAA_BBBB);
        xfer(0, 3'd4, 4'hF, 32'h0);
        drain();
        chk("args_be", last_rdata, 32'h1111_BBBB);

        // launch / busy / done
        xfer(1, 3'd0, 4'hF, 32'h1);
        xfer(1, 3'd1, 4'hF, 32'h1);
        idle(2);
        xfer(0, 3'd2, 4'hF, 32'h0);
        drain();
        chk("status_busy", last_rdata, 32'h1);
        xfer(1, 3'd1, 4'hF, 32'h1);
        idle(2);
        chk("start_pulses", 32'(n_start), 1);
        gpu_done_i = 1; tick(); gpu_done_i = 0;
        xfer(0, 3'd2, 4'hF, 32'h0);
        drain();
        chk("status_done", last_rdata, 32'h2);
        xfer(1, 3'd2, 4'hF, 32'h2);
        xfer(0, 3'd2, 4'hF, 32'h0);
        drain();
        chk("status_w1c", last_rdata, 32'h0);

        // done set wins over same-cycle W1C; START with same-cycle done is ignored
        xfer(1, 3'd1, 4'hF, 32'h1);
        drain();
        put(1, 3'd2, 4'hF, 32'h2); gpu_done_i = 1; wait_acc(); gpu_done_i = 0;
        xfer(1, 3'd1, 4'hF, 32'h1);
        drain();
        put(1, 3'd1, 4'hF, 32'h1); gpu_done_i = 1; wait_acc(); gpu_done_i = 0;
        idle(2);
        xfer(0, 3'd2, 4'hF, 32'h0);
        drain();
        chk("status_done_wins", last_rdata, 32'h2);
        chk("start_pulses2", 32'(n_start), 3);

        // back-pressure with a full response buffer
        xfer(1, 3'd5, 4'hF, 32'hDEAD_5A5A);
        drain();
        n_pop = 0;
        rready_i = 0;
        xfer(0, 3'd3, 4'hF, 32'h0);
        xfer(0, 3'd4, 4'hF, 32'h0);
        put(0, 3'd5, 4'hF, 32'h0);
        repeat (3) begin
            tick();
            chk("bp_gnt_held", 32'(gnt_o), 0);
        end
        rready_i = 1;
        wait_acc();
        drain();
        chk("bp_pops", 32'(n_pop), 3);
        chk("bp_last", last_rdata, 32'h0000_5A5A);

        // unmapped address
        xfer(0, 3'd7, 4'hF, 32'h0);
        drain();
        chk("unmapped_rd", last_rdata, DEAD);
        chk("unmapped_err", 32'(last_err), 1);
        xfer(1, 3'd7, 4'hF, 32'hFFFF_FFFF);
        drain();
        chk("unmapped_wr_kpc", kernel_pc_o, 32'h0000_1000);

        // performance counter slot
        xfer(1, 3'd1, 4'hF, 32'h1);
        idle(10);
        gpu_done_i = 1; tick(); gpu_done_i = 0;
        xfer(0, 3'd6, 4'hF, 32'h0);
        drain();
        if (PERF_EN) begin
            chk("perf_range", 32'(last_rdata >= 32'd9 && last_rdata <= 32'd11), 1);
            chk("perf_err", 32'(last_err), 0);
        end else begin
            chk("perf_absent_rd", last_rdata, DEAD);
            chk("perf_absent_err", 32'(last_err), 1);
        end

        // reset with responses pending
        rready_i = 0;
        xfer(0, 3'd3, 4'hF, 32'h0);
        xfer(0, 3'd4, 4'hF, 32'h0);
        do_reset(2);
        idle(2);

        // random traffic
        pend = 0;
        repeat (600) begin
            if (!pend && $urandom_range(0, 9) < 6) begin
                put(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), $urandom());
                pend = 1;
            end
            rready_i   = ($urandom_range(0, 3) != 0);
            gpu_done_i = ($urandom_range(0, 15) == 0);
            tick();
            if (last_acc) begin req_i = 0; pend = 0; end
        end
        gpu_done_i = 0;
        req_i = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conf_regs_obi_target.md
Name: conf_regs_obi_target

Overview:
- OBI responder for the e-GPU configuration register space; it terminates host-side `conf_regs_req`/`conf_regs_rsp` traffic inside `e_gpu`.
- Decodes word-aligned register accesses and applies byte enables.
- Returns responses through a small response buffer that supports host back-pressure.
- Produces a single-cycle kernel start pulse, and tracks busy/done against the GPU core.

Parameters:
- RSP_DEPTH, 2, response-buffer entries; limits accepted-but-unacknowledged transactions, range 1..4.
- ADDR_W, 32, OBI address width; only bits [4:2] are decoded.
- DEAD_VALUE, 32'hBADC0FFE, read data returned for unmapped addresses.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  OBI request
- we_i  in  1  write enable
- be_i  in  4  byte enables
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  write data
- gnt_o  out  1  OBI grant
- rvalid_o  out  1  response valid
- rready_i  in  1  host accepts response
- rdata_o  out  32  read data (0 on writes)
- err_o  out  1  unmapped-address flag, qualified by rvalid_o
- start_o  out  1  kernel launch pulse
- kernel_pc_o  out  32  KERNEL_PC register
- args_ptr_o  out  32  ARGS_PTR register
- num_groups_o  out  16  NUM_GROUPS[15:0]
- gpu_done_i  in  1  one-cycle completion pulse from the core

Behaviour:
- Clock and reset:
  - One clock, `clk_i`.
  - `rst_i` is synchronous and active-high. It clears all registers, empties the response buffer, and forces `gnt_o`, `rvalid_o`, `start_o` and `err_o` low.
  - Reset mid-transaction silently drops any pending responses.
- Register map (byte offsets):
  - 0x00 CTRL: RW, bit0 enable.
  - 0x04 START: write-only. Writing 1 to bit0 requests a launch. Reads return 0.
  - 0x08 STATUS: bit0 busy (RO); bit1 done (sticky, write-1-to-clear).
  - 0x0C KERNEL_PC: RW.
  - 0x10 ARGS_PTR: RW.
  - 0x14 NUM_GROUPS: RW, bits [15:0] only; upper bits read 0.
  - 0x18 PERF_CYC: only present when the optional feature is compiled in.
  - All other offsets are unmapped.
- Grant: `gnt_o = req_i & (occupancy < RSP_DEPTH)`, combinational. A transfer is accepted on any cycle with `req_i & gnt_o`.
- Write commit: on the acceptance edge. Only bytes with `be_i` set are updated. `addr_i[1:0]` is ignored.
- Read capture: rdata is captured into the buffer on the acceptance edge.
- Response timing:
  - The response is pushed on the acceptance edge, so `rvalid_o` asserts no earlier than the cycle after grant.
  - Responses pop in order when `rvalid_o & rready_i`.
  - A push and a pop in the same cycle keep occupancy unchanged.
  - A full buffer deasserts `gnt_o`; the request is held by the host.
- Unmapped address:
  - Writes are ignored.
  - Reads return DEAD_VALUE with `err_o=1`.
- Launch:
  - Accepted START write with bit0=1, CTRL.enable=1 and busy=0: `start_o` pulses high for exactly one cycle on the next clock, busy is set, and done is cleared.
  - START while busy or while disabled: ignored, no pulse.
- Completion:
  - `gpu_done_i` while busy clears busy and sets done.
  - `gpu_done_i` while idle is ignored.
  - `gpu_done_i` in the same cycle as a W1C of done: set wins.
  - START accepted in the same cycle as `gpu_done_i`: done is processed first; the start is ignored because busy was 1 at sample time.
- Register reads reflect state before any same-cycle write.

Optional Feature:
- Macro: `CONF_REGS_PERF_CNT_EN`.
- When defined:
  - 0x18 PERF_CYC is a 32-bit RO counter. It increments every cycle busy=1, wraps at 2^32, and clears on each accepted launch.
  - Writes to 0x18 are ignored, with `err_o=0`.
- When undefined:
  - 0x18 is unmapped (DEAD_VALUE, `err_o=1`) and no counter flops exist.

Decomposition:
- Package `conf_regs_pkg`:
  - Register offset localparams (CONF_CTRL_OFF … CONF_PERF_OFF).
  - Bit-index constants for STATUS/CTRL.
  - The `rsp_entry_t` struct {rdata[31:0], err}.
  - DEAD_VALUE default.
- One sub-module, `conf_rsp_fifo`: synchronous FIFO of `rsp_entry_t`, depth RSP_DEPTH, with push/pop/full/empty/count. Used for the response buffer.

Test Plan:
- Reset then write 0x0C=32'h0000_1000, read back, `rready_i=1` → `rvalid_o` one cycle after `gnt_o`, rdata=32'h0000_1000, `err_o=0`.
- Write 0x10 with `be_i=4'b0011`, data 32'hAAAA_BBBB over prior 32'h1111_2222 → read returns 32'h1111_BBBB.
- Write CTRL=1 then START=1 → `start_o` high exactly 1 cycle, STATUS=0x1. Second START → no pulse. Pulse `gpu_done_i` → STATUS=0x2. Write STATUS=0x2 → STATUS=0x0.
- Hold `rready_i=0` and issue 3 back-to-back reads with RSP_DEPTH=2 → third held with `gnt_o=0`. Release `rready_i` → three in-order responses, none lost.
- Read 0x1C → rdata=32'hBADC0FFE, `err_o=1`. Write 0x1C → no register changes.
- With `CONF_REGS_PERF_CNT_EN`: launch, wait 10 cycles, pulse `gpu_done_i`, read 0x18 → value 10 (±1 per documented edge). Without the macro → `err_o=1`.
